instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Front end of the ARMv8 (LEGv8-subset) core: holds the PC, issues word reads to instruction memory and presents one 32-bit instruction at a time to the instruction decoder. It accepts the taken-branch decision and the sign-extended branch offset back from the decode/execute side, and computes the next PC from them. Instruction memory may take any number of cycles to respond, so the block runs a request/ready handshake on the memory side and a valid/accept handshake on the decoder side.

Parameters:
PC_RESET, 64'h0, PC loaded on reset; bits [1:0] are forced to 0 internally.
COUNT_WIDTH, 32, width of the accepted-instruction counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
imemReq  output  1  read request to instruction memory.
imemAddr  output  64  byte address of the requested instruction word.
imemReady  input  1  memory data valid this cycle; only meaningful while imemReq=1.
imemData  input  32  instruction word returned by memory.
instruction  output  32  registered instruction word for the decoder.
instrValid  output  1  instruction/pc outputs are valid.
instrAccept  input  1  decoder/execute consumes the current instruction this cycle.
branchTaken  input  1  current instruction redirects the PC (B, or CBZ/CBNZ with the condition met).
branchOffset  input  64  sign-extended offset in words (output of the decode sign-extend unit).
pc  output  64  byte address of the presented instruction.
fetchCount  output  COUNT_WIDTH  number of instructions accepted since reset.

Behaviour:
- Reset is synchronous and active-high and overrides every other input. After a reset edge:
  - state=IDLE, imemReq=0, imemAddr=PC_RESET (aligned), instruction=0, instrValid=0, pc=PC_RESET, fetchCount=0.
  - An imemReady arriving in the reset cycle is ignored.
- States: IDLE, FETCH, HOLD.
  - IDLE: imemReq=0. Moves to FETCH on the next edge, so the first request comes one cycle after reset deasserts.
  - FETCH: imemReq=1, with imemAddr equal to the internal fetchPC and held stable until imemReady. When imemReady=1: instruction<=imemData, pc<=fetchPC, instrValid<=1, go to HOLD. While imemReady=0: stay in FETCH with outputs unchanged.
  - HOLD: imemReq=0; instruction and pc are held stable while instrValid=1. When instrAccept=1:
    - fetchPC<=nextPC, imemAddr<=nextPC, instrValid<=0, fetchCount<=fetchCount+1, go to FETCH.
    - When instrAccept=0: stay in HOLD and ignore branchTaken/branchOffset.
- nextPC is computed only from the instruction being accepted:
  - branchTaken=1: pc + (branchOffset<<2).
  - branchTaken=0: pc + 4.
- Arithmetic is 64-bit modulo 2^64. Incrementing 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. A negative offset subtracts through two's complement. Bits [1:0] of nextPC are always 0.
- fetchCount wraps to 0 after all ones.
- Throughput is one instruction per 2 cycles with a zero-wait memory: ready is seen in FETCH, then accept in HOLD. Latency from imemReady to instrValid is 1 cycle.
- instrAccept is legal only while instrValid=1. instrAccept and branchTaken outside HOLD have no effect.
- Reset in FETCH or HOLD aborts the operation: the outstanding request is dropped, the held instruction is discarded and the reset values apply.

Test Plan:
- Reset with PC_RESET=0 and imemReady tied to 1, imemData=32'h8B020020: imemReq rises 1 cycle after reset deasserts with imemAddr=0. Next cycle instrValid=1, instruction=32'h8B020020, pc=0. Assert instrAccept -> imemAddr=4, fetchCount=1.
- Memory wait: at fetchPC=8, hold imemReady=0 for 3 cycles -> imemReq=1 and imemAddr=8 stable, instrValid=0 for all 3 cycles. Ready on the 4th cycle -> instrValid next cycle with pc=8.
- Branches:
  - At pc=0x10, accept with branchTaken=1 and branchOffset=5 -> next imemAddr=0x24.
  - At pc=0x24, accept with branchTaken=1 and branchOffset=64'hFFFF_FFFF_FFFF_FFFE -> next imemAddr=0x1C.
  - At pc=0x1C, accept with branchTaken=0 -> next imemAddr=0x20.
- Decoder stall: keep instrAccept=0 for 4 cycles and pulse branchTaken=1 with offset 100 -> instruction, pc and instrValid stay unchanged and the branch has no effect. Accept with branchTaken=0 -> next address is pc+4.
- Wrap: PC_RESET=64'hFFFF_FFFF_FFFF_FFFC, accept with branchTaken=0 -> next imemAddr=0. Also preload fetchCount to all ones with COUNT_WIDTH=4; one accept -> 0.
- Reset mid-operation: assert reset in FETCH at imemAddr=0x40 with imemReady=1 in the same cycle -> instrValid stays 0, pc=PC_RESET, fetchCount=0, imemReq=0 for one cycle, then a fetch of PC_RESET.

Source files
------------

// File: rtl/instruction_fetch.sv
// Purpose : LEGv8 fetch front end; holds the PC, reads instruction memory, presents one word to decode.
// Latency : imemReady -> instrValid in 1 cycle; one instruction per 2 cycles with zero-wait memory.
// Backpressure: request held stable until imemReady; instruction/pc held in HOLD until instrAccept.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   imemReq/imemAddr             word read request to instruction memory (address held until ready)
//   imemReady/imemData           memory response, sampled only while imemReq=1
//   instruction/pc/instrValid    presented instruction and its byte address
//   instrAccept                  decoder consumes the presented instruction
//   branchTaken/branchOffset     redirect for the accepted instruction (offset in words)
//   fetchCount                   accepted-instruction counter, wraps
module instruction_fetch #(
  parameter logic [63:0] PC_RESET    = 64'h0,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imemReq,
  output logic [63:0]            imemAddr,
  input  logic                   imemReady,
  input  logic [31:0]            imemData,
  output logic [31:0]            instruction,
  output logic                   instrValid,
  input  logic                   instrAccept,
  input  logic                   branchTaken,
  input  logic [63:0]            branchOffset,
  output logic [63:0]            pc,
  output logic [COUNT_WIDTH-1:0] fetchCount
);

  // Reset PC is word aligned regardless of how the parameter is given.
  localparam logic [63:0] PC_RESET_ALIGNED = {PC_RESET[63:2], 2'b00};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [63:0]            r_fetch_pc;
  logic [31:0]            r_instr;
  logic                   r_valid;
  logic [63:0]            r_pc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_load_instr;
  logic                   w_accept;
  logic [63:0]            w_next_pc;

  // Next PC derives only from the presented (accepted) instruction's pc.
  // r_pc is always aligned and the offset is shifted by 2, so bits [1:0] stay 0.
  assign w_next_pc = r_pc + (branchTaken ? (branchOffset << 2) : 64'd4);

  always_comb begin
    w_state_next = r_state;
    w_load_instr = 1'b0;
    w_accept     = 1'b0;
    imemReq      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          w_load_instr = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        // Branch inputs are only meaningful together with the accept.
        if (instrAccept) begin
          w_accept     = 1'b1;
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= PC_RESET_ALIGNED;
      r_instr    <= 32'h0;
      r_valid    <= 1'b0;
      r_pc       <= PC_RESET_ALIGNED;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_instr) begin
        r_instr <= imemData;
        r_pc    <= r_fetch_pc;
        r_valid <= 1'b1;
      end
      if (w_accept) begin
        r_fetch_pc <= w_next_pc;
        r_valid    <= 1'b0;
        r_count    <= r_count + CNT_ONE;
      end
    end
  end

  assign imemAddr    = r_fetch_pc;
  assign instruction = r_instr;
  assign instrValid  = r_valid;
  assign pc          = r_pc;
  assign fetchCount  = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: main instance with PC_RESET=0, and a
// second instance with an unaligned all-ones PC_RESET and a 4-bit counter for wrap cases.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Main instance
  logic        reset;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic        instrValid;
  logic        instrAccept;
  logic        branchTaken;
  logic [63:0] branchOffset;
  logic [63:0] pc;
  logic [31:0] fetchCount;

  instruction_fetch #(.PC_RESET(64'h0), .COUNT_WIDTH(32)) u0 (
    .clock(clock), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemData(imemData), .instruction(instruction),
    .instrValid(instrValid), .instrAccept(instrAccept), .branchTaken(branchTaken),
    .branchOffset(branchOffset), .pc(pc), .fetchCount(fetchCount)
  );

  // Wrap instance
  logic        w_reset;
  logic        w_imemReq;
  logic [63:0] w_imemAddr;
  logic        w_imemReady;
  logic [31:0] w_imemData;
  logic [31:0] w_instruction;
  logic        w_instrValid;
  logic        w_instrAccept;
  logic        w_branchTaken;
  logic [63:0] w_branchOffset;
  logic [63:0] w_pc;
  logic [3:0]  w_fetchCount;

  instruction_fetch #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFF), .COUNT_WIDTH(4)) u1 (
    .clock(clock), .reset(w_reset), .imemReq(w_imemReq), .imemAddr(w_imemAddr),
    .imemReady(w_imemReady), .imemData(w_imemData), .instruction(w_instruction),
    .instrValid(w_instrValid), .instrAccept(w_instrAccept), .branchTaken(w_branchTaken),
    .branchOffset(w_branchOffset), .pc(w_pc), .fetchCount(w_fetchCount)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accept in HOLD on the main instance.
  task automatic accept_main(input logic taken, input logic [63:0] off);
    instrAccept  = 1'b1;
    branchTaken  = taken;
    branchOffset = off;
    step();
    instrAccept  = 1'b0;
    branchTaken  = 1'b0;
    branchOffset = 64'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imemReady = 1'b1; imemData = 32'h8B020020;
    instrAccept = 1'b0; branchTaken = 1'b0; branchOffset = 64'h0;
    step();
    step();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imemReq); end
    checks++; if (imemAddr !== 64'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imemAddr); end
    checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instrValid); end
    checks++; if (pc !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (fetchCount !== 32'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetchCount); end
    reset = 1'b0;
    step();  // IDLE -> FETCH
    checks++; if (imemReq !== 1'b1 || imemAddr !== 64'h0 || instrValid !== 1'b0)
      begin failures++; $display("FAIL first_req req=%0b addr=%h valid=%0b exp req=1 addr=0 valid=0", imemReq, imemAddr, instrValid); end
    step();  // ready seen -> HOLD
    checks++; if (instrValid !== 1'b1 || instruction !== 32'h8B020020 || pc !== 64'h0 || imemReq !== 1'b0)
      begin failures++; $display("FAIL first_instr valid=%0b instr=%h pc=%h req=%0b exp 1/8b020020/0/0", instrValid, instruction, pc, imemReq); end
    accept_main(1'b0, 64'h0);
    checks++; if (imemAddr !== 64'h4 || fetchCount !== 32'd1 || instrValid !== 1'b0 || imemReq !== 1'b1)
      begin failures++; $display("FAIL first_accept addr=%h count=%0d valid=%0b req=%0b exp 4/1/0/1", imemAddr, fetchCount, instrValid, imemReq); end
  endtask

  task automatic test_mem_wait();
    step();                      // HOLD at pc=4
    accept_main(1'b0, 64'h0);    // FETCH at 8, count=2
    imemReady = 1'b0;
    imemData  = 32'hF9400001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imemReq !== 1'b1 || imemAddr !== 64'h8 || instrValid !== 1'b0)
        begin failures++; $display("FAIL wait_cycle%0d req=%0b addr=%h valid=%0b exp 1/8/0", i, imemReq, imemAddr, instrValid); end
    end
    imemReady = 1'b1;
    step();
    checks++; if (instrValid !== 1'b1 || pc !== 64'h8 || instruction !== 32'hF9400001)
      begin failures++; $display("FAIL wait_done valid=%0b pc=%h instr=%h exp 1/8/f9400001", instrValid, pc, instruction); end
  endtask

  task automatic test_branches();
    accept_main(1'b0, 64'h0);    // -> C, count 3
    step();
    accept_main(1'b0, 64'h0);    // -> 10, count 4
    step();
    checks++; if (pc !== 64'h10) begin failures++; $display("FAIL br_setup pc=%h exp=10", pc); end
    accept_main(1'b1, 64'd5);
    checks++; if (imemAddr !== 64'h24) begin failures++; $display("FAIL br_fwd addr=%h exp=24", imemAddr); end
    step();
    accept_main(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    checks++; if (imemAddr !== 64'h1C) begin failures++; $display("FAIL br_back addr=%h exp=1c", imemAddr); end
    step();
    checks++; if (pc !== 64'h1C) begin failures++; $display("FAIL br_back_pc pc=%h exp=1c", pc); end
    accept_main(1'b0, 64'h0);
    checks++; if (imemAddr !== 64'h20 || fetchCount !== 32'd7)
      begin failures++; $display("FAIL br_not addr=%h count=%0d exp 20/7", imemAddr, fetchCount); end
  endtask

  task automatic test_stall();
    imemData = 32'hD2800041;
    step();                      // HOLD at pc=20
    imemData = 32'h12345678;     // must not leak into the held instruction
    for (int i = 0; i < 4; i++) begin
      branchTaken  = (i == 1);
      branchOffset = 64'd100;
      step();
      checks++; if (instrValid !== 1'b1 || pc !== 64'h20 || instruction !== 32'hD2800041 || imemReq !== 1'b0)
        begin failures++; $display("FAIL stall_cycle%0d valid=%0b pc=%h instr=%h req=%0b exp 1/20/d2800041/0", i, instrValid, pc, instruction, imemReq); end
    end
    branchTaken = 1'b0;
    accept_main(1'b0, 64'h0);
    checks++; if (imemAddr !== 64'h24 || fetchCount !== 32'd8)
      begin failures++; $display("FAIL stall_accept addr=%h count=%0d exp 24/8", imemAddr, fetchCount); end
  endtask

  task automatic test_reset_mid();
    step();                      // HOLD at pc=24
    accept_main(1'b1, 64'd7);    // 0x24 + 28 = 0x40
    checks++; if (imemReq !== 1'b1 || imemAddr !== 64'h40)
      begin failures++; $display("FAIL mid_setup req=%0b addr=%h exp 1/40", imemReq, imemAddr); end
    reset = 1'b1; imemReady = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (instrValid !== 1'b0 || pc !== 64'h0 || fetchCount !== 32'd0 || imemReq !== 1'b0 || imemAddr !== 64'h0)
      begin failures++; $display("FAIL mid_reset valid=%0b pc=%h count=%0d req=%0b addr=%h exp 0/0/0/0/0", instrValid, pc, fetchCount, imemReq, imemAddr); end
    step();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 64'h0 || instrValid !== 1'b0)
      begin failures++; $display("FAIL mid_refetch req=%0b addr=%h valid=%0b exp 1/0/0", imemReq, imemAddr, instrValid); end
  endtask

  task automatic test_wrap();
    w_reset = 1'b1;
    step();
    w_reset = 1'b0;
    checks++; if (w_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_imemAddr !== 64'hFFFF_FFFF_FFFF_FFFC || w_fetchCount !== 4'd0)
      begin failures++; $display("FAIL wrap_reset pc=%h addr=%h count=%0d exp fffffffffffffffc/fffffffffffffffc/0", w_pc, w_imemAddr, w_fetchCount); end
    step();                      // FETCH
    step();                      // HOLD
    w_instrAccept = 1'b1;
    step();
    w_instrAccept = 1'b0;
    checks++; if (w_imemAddr !== 64'h0 || w_fetchCount !== 4'd1)
      begin failures++; $display("FAIL wrap_pc addr=%h count=%0d exp 0/1", w_imemAddr, w_fetchCount); end
    for (int i = 0; i < 14; i++) begin
      step();
      w_instrAccept = 1'b1;
      step();
      w_instrAccept = 1'b0;
    end
    checks++; if (w_fetchCount !== 4'hF) begin failures++; $display("FAIL wrap_cnt_full count=%0d exp 15", w_fetchCount); end
    step();
    w_instrAccept = 1'b1;
    step();
    w_instrAccept = 1'b0;
    checks++; if (w_fetchCount !== 4'h0) begin failures++; $display("FAIL wrap_cnt count=%0d exp 0", w_fetchCount); end
  endtask

  initial begin
    reset = 1'b1; imemReady = 1'b0; imemData = 32'h0;
    instrAccept = 1'b0; branchTaken = 1'b0; branchOffset = 64'h0;
    w_reset = 1'b1; w_imemReady = 1'b1; w_imemData = 32'hAA550000;
    w_instrAccept = 1'b0; w_branchTaken = 1'b0; w_branchOffset = 64'h0;
    test_reset();
    test_mem_wait();
    test_branches();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
